id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register of the RV32I core. It sits directly downstream of the register file: it captures decoded fields and the two regfile read values, and resolves RAW hazards by forwarding from the EX, MEM and WB stages. It inserts one bubble for a load-use hazard and presents a registered, valid/ready-handshaked operand packet to the EX stage.

Parameters:
XLEN, 32, datapath/operand width
PAYLOAD_W, 96, opaque pass-through bits (pc, imm, ALU/branch ctrl) carried from decode to EX

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_flush  in  1  branch/jump redirect; kill in-flight packet
i_valid  in  1  decode packet valid
o_ready  out  1  stage can accept decode packet this cycle
i_payload  in  PAYLOAD_W  pass-through bits
i_rs1_addr  in  5  source 1 index (same value driven to regfile rs1 port)
i_rs2_addr  in  5  source 2 index
i_rd_addr  in  5  destination index
i_rd_wren  in  1  instruction writes rd
i_is_load  in  1  instruction is a load
i_rf_rs1_data  in  XLEN  regfile read port 1 data
i_rf_rs2_data  in  XLEN  regfile read port 2 data
i_ex_rd_data  in  XLEN  combinational EX result of the packet currently held in this stage
i_mem_rd_addr  in  5  MEM-stage destination
i_mem_rd_wren  in  1  MEM-stage writes rd
i_mem_rd_data  in  XLEN  MEM-stage final result, load data included
i_wb_rd_addr  in  5  WB destination (same signal as regfile write address)
i_wb_rd_wren  in  1  WB write enable
i_wb_rd_data  in  XLEN  WB write data
i_ex_ready  in  1  EX accepts held packet this cycle
o_valid  out  1  held packet valid
o_payload  out  PAYLOAD_W  registered payload
o_rs1_data  out  XLEN  resolved operand 1
o_rs2_data  out  XLEN  resolved operand 2
o_rd_addr  out  5  registered rd
o_rd_wren  out  1  registered rd write enable
o_is_load  out  1  registered load flag

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs and state are 0, including o_valid. Release is synchronous to i_clk.
- Handshake: `accept = i_valid & o_ready`; `drain = o_valid & i_ex_ready`. Either side may hold valid while waiting; payload is stable while o_valid=1 and i_ex_ready=0.
- Hazard: `load_use = o_valid & o_is_load & o_rd_wren & (o_rd_addr!=0) & i_valid & (i_rs1_addr==o_rd_addr | i_rs2_addr==o_rd_addr)`. The check is conservative and ignores whether the source is actually used.
- Ready: `o_ready = (~o_valid | i_ex_ready) & ~load_use`. It is combinational, with no dependency on i_flush.
- Register update at posedge, in priority order:
  - i_flush: o_valid<=0, and any packet accepted this cycle is discarded.
  - Otherwise, accept: load all fields and the resolved operands; o_valid<=1.
  - Otherwise, drain: o_valid<=0 (a bubble on load_use).
  - Otherwise: hold.
- Operand resolution (per source s, combinational, captured on accept). First match wins:
  - s==0 gives 0.
  - EX: o_valid & o_rd_wren & ~o_is_load & o_rd_addr==s gives i_ex_rd_data.
  - MEM: i_mem_rd_wren & i_mem_rd_addr==s gives i_mem_rd_data.
  - WB: i_wb_rd_wren & i_wb_rd_addr==s gives i_wb_rd_data. This is required because the regfile has no write-through.
  - Otherwise the regfile data is used.
- Load-use latency: exactly one bubble. After it the load sits in MEM, and the dependent packet is accepted next cycle via MEM forwarding.
- Bubbles and flushed slots may leave stale fields. Only o_valid is meaningful, and EX must gate on it.
- x0 is never forwarded, even if a producer has rd=0 with wren=1.

Test Plan:
- Reset: drive i_reset=0 mid-stream with o_valid=1 -> all outputs 0 immediately. After release, the first accepted packet appears one cycle later with o_valid=1.
- EX forward: `addi x5` (EX result 0x11) followed by `add x6,x5,x5`, with regfile x5=0 -> o_rs1_data=o_rs2_data=0x11.
- Forward priority: MEM x7=0xA, WB x7=0xB, regfile x7=0xC, no EX match -> operand 0xA. Drop MEM -> 0xB. Drop WB -> 0xC. Source x0 with all forwards targeting x0 =0xFF -> 0.
- Load-use: `lw x8` held, next packet reads x8, i_ex_ready=1 -> o_ready=0, then o_valid=0 for one cycle. Next cycle, with MEM x8=0xDEAD, the packet is accepted with o_rs1_data=0xDEAD.
- Backpressure: o_valid=1, i_ex_ready=0 for 3 cycles with i_valid=1 -> o_ready=0 and outputs unchanged. Raise i_ex_ready -> the new packet is loaded the following edge.
- Flush: i_flush=1 with accept and drain both active -> o_valid=0 next cycle, and the accepted packet never appears on the outputs.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX register: captures decode fields, resolves RAW operands by EX/MEM/WB forwarding, one-bubble load-use stall.
// Latency 1 cycle; o_ready drops while EX stalls or on a load-use hazard, and the held packet stays stable until drained.
module id_ex_operand_stage #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 96
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [4:0]           i_rs1_addr,
  input  logic [4:0]           i_rs2_addr,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_rd_wren,
  input  logic                 i_is_load,
  input  logic [XLEN-1:0]      i_rf_rs1_data,
  input  logic [XLEN-1:0]      i_rf_rs2_data,
  input  logic [XLEN-1:0]      i_ex_rd_data,
  input  logic [4:0]           i_mem_rd_addr,
  input  logic                 i_mem_rd_wren,
  input  logic [XLEN-1:0]      i_mem_rd_data,
  input  logic [4:0]           i_wb_rd_addr,
  input  logic                 i_wb_rd_wren,
  input  logic [XLEN-1:0]      i_wb_rd_data,
  input  logic                 i_ex_ready,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_rs2_data,
  output logic [4:0]           o_rd_addr,
  output logic                 o_rd_wren,
  output logic                 o_is_load
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic                 rd_wren_q, rd_wren_d;
  logic                 is_load_q, is_load_d;

  logic                 load_use;
  logic                 accept;
  logic                 drain;
  logic [XLEN-1:0]      rs1_fwd;
  logic [XLEN-1:0]      rs2_fwd;

  // A load's data only exists in MEM, so the EX path never forwards a load.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0]      src,
                                               input logic [XLEN-1:0] rf_data);
    if (src == 5'd0)
      return '0;
    else if (valid_q && rd_wren_q && !is_load_q && (rd_addr_q == src))
      return i_ex_rd_data;
    else if (i_mem_rd_wren && (i_mem_rd_addr == src))
      return i_mem_rd_data;
    else if (i_wb_rd_wren && (i_wb_rd_addr == src))
      return i_wb_rd_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    load_use = valid_q & is_load_q & rd_wren_q & (rd_addr_q != 5'd0) & i_valid &
               ((i_rs1_addr == rd_addr_q) | (i_rs2_addr == rd_addr_q));
    o_ready  = (~valid_q | i_ex_ready) & ~load_use;
    accept   = i_valid & o_ready;
    drain    = valid_q & i_ex_ready;
    rs1_fwd  = resolve(i_rs1_addr, i_rf_rs1_data);
    rs2_fwd  = resolve(i_rs2_addr, i_rf_rs2_data);
  end

  always_comb begin
    valid_d    = valid_q;
    payload_d  = payload_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_addr_d  = rd_addr_q;
    rd_wren_d  = rd_wren_q;
    is_load_d  = is_load_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      payload_d  = i_payload;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
      rd_addr_d  = i_rd_addr;
      rd_wren_d  = i_rd_wren;
      is_load_d  = i_is_load;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q    <= 1'b0;
      payload_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_addr_q  <= '0;
      rd_wren_q  <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      payload_q  <= payload_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_wren_q  <= rd_wren_d;
      is_load_q  <= is_load_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_payload  = payload_q;
  assign o_rs1_data = rs1_data_q;
  assign o_rs2_data = rs2_data_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_wren  = rd_wren_q;
  assign o_is_load  = is_load_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic against a packet-level model.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int PW   = 96;

  logic          i_clk = 1'b0;
  logic          i_reset, i_flush, i_valid, o_ready;
  logic [PW-1:0] i_payload, o_payload;
  logic [4:0]    i_rs1_addr, i_rs2_addr, i_rd_addr, i_mem_rd_addr, i_wb_rd_addr, o_rd_addr;
  logic          i_rd_wren, i_is_load, i_mem_rd_wren, i_wb_rd_wren, i_ex_ready;
  logic [31:0]   i_rf_rs1_data, i_rf_rs2_data, i_ex_rd_data, i_mem_rd_data, i_wb_rd_data;
  logic          o_valid, o_rd_wren, o_is_load;
  logic [31:0]   o_rs1_data, o_rs2_data;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_payload(i_payload), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rd_wren(i_rd_wren), .i_is_load(i_is_load), .i_rf_rs1_data(i_rf_rs1_data),
    .i_rf_rs2_data(i_rf_rs2_data), .i_ex_rd_data(i_ex_rd_data), .i_mem_rd_addr(i_mem_rd_addr),
    .i_mem_rd_wren(i_mem_rd_wren), .i_mem_rd_data(i_mem_rd_data), .i_wb_rd_addr(i_wb_rd_addr),
    .i_wb_rd_wren(i_wb_rd_wren), .i_wb_rd_data(i_wb_rd_data), .i_ex_ready(i_ex_ready),
    .o_valid(o_valid), .o_payload(o_payload), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren), .o_is_load(o_is_load)
  );

  always #5 i_clk = ~i_clk;

  // Model of the packet held in the stage.
  typedef struct {
    logic          v;
    logic [PW-1:0] pl;
    logic [31:0]   a, b;
    logic [4:0]    rd;
    logic          wr, ld;
  } pkt_t;
  pkt_t m;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_valid = 0; i_payload = '0;
    i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_rd_wren = 0; i_is_load = 0;
    i_rf_rs1_data = 0; i_rf_rs2_data = 0; i_ex_rd_data = 0;
    i_mem_rd_addr = 0; i_mem_rd_wren = 0; i_mem_rd_data = 0;
    i_wb_rd_addr = 0; i_wb_rd_wren = 0; i_wb_rd_data = 0;
    i_ex_ready = 1;
  endtask

  task automatic pkt(input logic [PW-1:0] pl, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wr, input logic ld);
    i_valid = 1; i_payload = pl; i_rs1_addr = rs1; i_rs2_addr = rs2;
    i_rd_addr = rd; i_rd_wren = wr; i_is_load = ld;
  endtask

  task automatic test_reset();
    i_reset = 0;
    idle();
    #2;
    tests++; if ({o_valid, o_payload, o_rs1_data, o_rs2_data, o_rd_addr, o_rd_wren, o_is_load} !== '0) begin
      fails++; $display("FAIL reset_init: outputs not zero (valid=%b payload=%h)", o_valid, o_payload);
    end
    #5 i_reset = 1;
    tick();
    pkt(96'hA5A5, 5'd1, 5'd2, 5'd3, 1, 0);
    i_rf_rs1_data = 32'h1; i_rf_rs2_data = 32'h2;
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL reset_live_valid: got %b want 1", o_valid); end
    // Asynchronous assert mid-cycle.
    #2 i_reset = 0;
    #1;
    tests++; if ({o_valid, o_payload, o_rs1_data, o_rs2_data, o_rd_addr, o_rd_wren, o_is_load} !== '0) begin
      fails++; $display("FAIL reset_async: valid=%b payload=%h rs1=%h rd=%0d", o_valid, o_payload, o_rs1_data, o_rd_addr);
    end
    tick();
    #2 i_reset = 1;
    pkt(96'hBEEF_0001, 5'd1, 5'd2, 5'd4, 1, 0);
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    tick();
    tests++; if (o_valid !== 1'b1 || o_payload !== 96'hBEEF_0001 || o_rd_addr !== 5'd4) begin
      fails++; $display("FAIL reset_first_pkt: valid=%b payload=%h rd=%0d want 1/beef0001/4", o_valid, o_payload, o_rd_addr);
    end
  endtask

  task automatic test_ex_forward();
    idle();
    pkt(96'h1, 5'd0, 5'd0, 5'd5, 1, 0);     // addi x5
    tick();
    pkt(96'h2, 5'd5, 5'd5, 5'd6, 1, 0);     // add x6,x5,x5
    i_ex_rd_data = 32'h11;
    tick();
    tests++; if (o_rs1_data !== 32'h11 || o_rs2_data !== 32'h11 || o_rd_addr !== 5'd6) begin
      fails++; $display("FAIL ex_forward: rs1=%h rs2=%h rd=%0d want 11/11/6", o_rs1_data, o_rs2_data, o_rd_addr);
    end
  endtask

  task automatic test_forward_priority();
    logic [31:0] exp [3];
    exp[0] = 32'hA; exp[1] = 32'hB; exp[2] = 32'hC;
    for (int c = 0; c < 3; c++) begin
      idle();
      pkt(96'h10 + c, 5'd7, 5'd7, 5'd9, 0, 0);
      i_rf_rs1_data = 32'hC; i_rf_rs2_data = 32'hC;
      i_mem_rd_addr = 5'd7; i_mem_rd_data = 32'hA; i_mem_rd_wren = (c == 0);
      i_wb_rd_addr  = 5'd7; i_wb_rd_data  = 32'hB; i_wb_rd_wren  = (c <= 1);
      tick();
      tests++; if (o_rs1_data !== exp[c] || o_rs2_data !== exp[c]) begin
        fails++; $display("FAIL fwd_priority_%0d: rs1=%h rs2=%h want %h", c, o_rs1_data, o_rs2_data, exp[c]);
      end
    end
    // x0 is never forwarded, even from a producer that "writes" x0.
    idle();
    pkt(96'h20, 5'd1, 5'd1, 5'd0, 1, 0);
    tick();
    pkt(96'h21, 5'd0, 5'd0, 5'd3, 1, 0);
    i_ex_rd_data = 32'hFF; i_rf_rs1_data = 32'hFF; i_rf_rs2_data = 32'hFF;
    i_mem_rd_addr = 0; i_mem_rd_wren = 1; i_mem_rd_data = 32'hFF;
    i_wb_rd_addr = 0; i_wb_rd_wren = 1; i_wb_rd_data = 32'hFF;
    tick();
    tests++; if (o_rs1_data !== 32'h0 || o_rs2_data !== 32'h0) begin
      fails++; $display("FAIL x0_operand: rs1=%h rs2=%h want 0", o_rs1_data, o_rs2_data);
    end
  endtask

  task automatic test_load_use();
    idle();
    pkt(96'h30, 5'd0, 5'd0, 5'd8, 1, 1);    // lw x8
    tick();
    pkt(96'h31, 5'd8, 5'd1, 5'd10, 1, 0);
    i_rf_rs1_data = 32'h5555; i_rf_rs2_data = 32'h1234;
    #1;
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL load_use_ready: got %b want 0", o_ready); end
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL load_use_bubble: valid=%b want 0", o_valid); end
    i_mem_rd_addr = 5'd8; i_mem_rd_wren = 1; i_mem_rd_data = 32'hDEAD;
    #1;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL load_use_resume: ready=%b want 1", o_ready); end
    tick();
    tests++; if (o_valid !== 1'b1 || o_rs1_data !== 32'hDEAD || o_rs2_data !== 32'h1234 || o_payload !== 96'h31) begin
      fails++; $display("FAIL load_use_fwd: valid=%b rs1=%h rs2=%h pl=%h want 1/dead/1234/31", o_valid, o_rs1_data, o_rs2_data, o_payload);
    end
  endtask

  task automatic test_backpressure();
    idle();
    pkt(96'h40, 5'd1, 5'd2, 5'd3, 1, 0);
    i_rf_rs1_data = 32'h77;
    tick();
    pkt(96'h41, 5'd4, 5'd5, 5'd6, 1, 0);
    i_rf_rs1_data = 32'h88;
    i_ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0", k, o_ready); end
      tick();
      tests++; if (o_valid !== 1'b1 || o_payload !== 96'h40 || o_rs1_data !== 32'h77 || o_rd_addr !== 5'd3) begin
        fails++; $display("FAIL bp_hold_%0d: valid=%b pl=%h rs1=%h rd=%0d want 1/40/77/3", k, o_valid, o_payload, o_rs1_data, o_rd_addr);
      end
    end
    i_ex_ready = 1;
    #1;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
    tick();
    tests++; if (o_valid !== 1'b1 || o_payload !== 96'h41 || o_rs1_data !== 32'h88) begin
      fails++; $display("FAIL bp_release_load: valid=%b pl=%h rs1=%h want 1/41/88", o_valid, o_payload, o_rs1_data);
    end
  endtask

  task automatic test_flush();
    idle();
    pkt(96'h50, 5'd1, 5'd2, 5'd3, 1, 0);
    tick();
    pkt(96'h51, 5'd1, 5'd2, 5'd4, 1, 0);
    i_flush = 1;
    #1;
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", o_ready); end
    tick();
    idle();
    i_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tests++; if (o_valid !== 1'b0 || o_payload === 96'h51) begin
        fails++; $display("FAIL flush_kill_%0d: valid=%b pl=%h want valid 0 and no pl 51", k, o_valid, o_payload);
      end
      tick();
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 32'h0;
    if (m.v && m.wr && !m.ld && m.rd == s) return i_ex_rd_data;
    if (i_mem_rd_wren && i_mem_rd_addr == s) return i_mem_rd_data;
    if (i_wb_rd_wren && i_wb_rd_addr == s) return i_wb_rd_data;
    return rf;
  endfunction

  task automatic test_random();
    logic hazard, exp_ready, acc;
    idle();
    i_valid = 0;
    tick();                                  // drains whatever is held
    m.v = 0; m.pl = '0; m.a = 0; m.b = 0; m.rd = 0; m.wr = 0; m.ld = 0;
    for (int n = 0; n < 400; n++) begin
      i_flush       = ($urandom_range(0, 15) == 0);
      i_valid       = ($urandom_range(0, 9) < 7);
      i_ex_ready    = ($urandom_range(0, 9) < 7);
      i_payload     = {$urandom, $urandom, $urandom};
      i_rs1_addr    = 5'($urandom_range(0, 3));
      i_rs2_addr    = 5'($urandom_range(0, 3));
      i_rd_addr     = 5'($urandom_range(0, 3));
      i_rd_wren     = 1'($urandom_range(0, 1));
      i_is_load     = ($urandom_range(0, 9) < 3);
      i_rf_rs1_data = $urandom; i_rf_rs2_data = $urandom; i_ex_rd_data = $urandom;
      i_mem_rd_addr = 5'($urandom_range(0, 3)); i_mem_rd_wren = 1'($urandom_range(0, 1)); i_mem_rd_data = $urandom;
      i_wb_rd_addr  = 5'($urandom_range(0, 3)); i_wb_rd_wren  = 1'($urandom_range(0, 1)); i_wb_rd_data  = $urandom;
      #1;
      tests++; if (o_valid !== m.v) begin fails++; $display("FAIL rnd_valid @%0d: got %b want %b", n, o_valid, m.v); end
      if (m.v) begin
        tests++; if (o_payload !== m.pl || o_rs1_data !== m.a || o_rs2_data !== m.b ||
                     o_rd_addr !== m.rd || o_rd_wren !== m.wr || o_is_load !== m.ld) begin
          fails++; $display("FAIL rnd_fields @%0d: rs1=%h/%h rs2=%h/%h rd=%0d/%0d", n, o_rs1_data, m.a, o_rs2_data, m.b, o_rd_addr, m.rd);
        end
      end
      hazard    = m.v && m.ld && m.wr && m.rd != 0 && i_valid && (i_rs1_addr == m.rd || i_rs2_addr == m.rd);
      exp_ready = (!m.v || i_ex_ready) && !hazard;
      tests++; if (o_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready @%0d: got %b want %b", n, o_ready, exp_ready); end
      acc = i_valid && exp_ready;
      if (i_flush) m.v = 0;
      else if (acc) begin
        m.a  = ref_operand(i_rs1_addr, i_rf_rs1_data);
        m.b  = ref_operand(i_rs2_addr, i_rf_rs2_data);
        m.v  = 1; m.pl = i_payload; m.rd = i_rd_addr; m.wr = i_rd_wren; m.ld = i_is_load;
      end else if (m.v && i_ex_ready) m.v = 0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_forward_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
